regfile_wr_arbiter: RTL
=======================

# regfile_wr_arbiter

Shares the register file's single write port (WE3/A3/WD3) among N_REQ writeback requesters, such as ALU writeback, load return and CSR/debug, using a valid/ready handshake and round-robin priority. It sits between the writeback sources and the register file. It registers the selected write onto the port and discards writes to x0. An optional post-reset sweep clears x1–x31 before any requester is served.

## Interface
- N_REQ, 2, number of requesters (2–8)
- XLEN, 32, data width
- AW, 5, register address width
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low (rst=0 resets)
- hold  in  1  freeze arbitration: no grants while high
- req_valid  in  N_REQ  requester i has a write pending
- req_addr  in  N_REQ*AW  packed destination addresses, slice i = requester i
- req_data  in  N_REQ*XLEN  packed write data
- req_ready  out  N_REQ  one-hot grant, combinational; a transfer happens when valid&ready are both high at a clock edge
- we_o  out  1  to WE3, registered
- waddr_o  out  AW  to A3, registered
- wdata_o  out  XLEN  to WD3, registered
- init_done  out  1  high once the arbiter is serving requesters

## Operation
- States: CLEAR (only with the macro), ARB.
- ARB, hold=0:
  - Grant the first valid requester searching from ptr+1 upward, wrapping modulo N_REQ.
  - ptr resets to N_REQ-1, so requester 0 has first priority.
- On a transfer:
  - ptr ← granted index.
  - Next edge: we_o=1, waddr_o/wdata_o ← granted addr/data.
- Transfer with addr 0: the requester is still acked and ptr still advances; we_o=0 next cycle, so the x0 write is dropped.
- No transfer, or hold=1: req_ready=0 and we_o=0 next cycle. ptr unchanged.
- At most one bit of req_ready is high; a requester that drops valid loses its turn.
- req_ready=0 whenever init_done=0.

## Timing
- Reset values: we_o=0, waddr_o=0, wdata_o=0, init_done=0, ptr=N_REQ-1.
- State after reset: CLEAR with the macro, ARB without.
- Latency:
  - Edge k: transfer.
  - Cycle k..k+1: we_o/waddr_o/wdata_o valid.
  - Edge k+1: the register file captures the value.
  - The register's readback reflects the new value in the cycle after edge k+1.
- Throughput: one write per cycle, sustained.
- Without the macro, init_done rises at the first edge after reset release; grants are possible from that cycle onward.
- Asserting reset mid-operation aborts everything immediately, including a CLEAR sweep, and forces the reset values. A write on the outputs is lost.
- The block does not forward pending writes; bypass is the caller's responsibility.

## Configuration
- REGFILE_CLEAR_EN defined:
  - After reset the block sits in CLEAR; 5-bit idx starts at 1.
  - Each edge drives we_o=1, waddr_o=idx, wdata_o=0, then idx+1.
  - init_done is set on the edge that drives idx=31, and the state moves to ARB.
  - The sweep issues 31 writes in 31 consecutive cycles; hold is ignored during CLEAR.
- REGFILE_CLEAR_EN undefined: no CLEAR state and no idx counter; behaviour is as in Timing.

## Structure
- Package regfile_ctrl_pkg holds:
  - the state enum (S_CLEAR, S_ARB)
  - XLEN/AW defaults
  - the constant REG_LAST=31
- Sub-module rr_arbiter (N parameter): combinational one-hot grant from the req vector and ptr.
- The top level owns ptr update, the output registers, the CLEAR FSM and the x0 filter.

## Test plan
- Reset, no macro: release rst, hold requester 0 valid (addr 5, data 0x0000_000A) → ready[0] high in the first cycle. Next cycle: we_o=1, waddr_o=5, wdata_o=0xA. RD of x5 reads 0xA afterwards.
- Contention, N_REQ=2: both valid continuously (r0: addr 3/0x11, r1: addr 4/0x22) → grants alternate 0,1,0,1. Outputs alternate 3/0x11, 4/0x22 with we_o continuously high.
- x0 drop: r1 valid, addr 0, data 0xFFFF_FFFF → ready[1] pulses and ptr advances. we_o stays 0; x0 still reads 0.
- hold: both valid with hold=1 for 3 cycles → req_ready=0 and we_o=0 throughout. When hold drops, the first grant goes to the requester after the last granted one.
- REGFILE_CLEAR_EN: release rst → waddr_o=1..31 with wdata_o=0 for 31 cycles, req_ready=0 during the sweep. init_done rises with waddr_o=31; a pending r0 write appears on the next cycle.
- Reset mid-operation: assert rst during a CLEAR sweep at idx 10 and during streaming writes → outputs return to 0 without waiting for a clock. After release the sweep restarts at 1, and grant priority restarts at requester 0.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file write arbiter.
package regfile_ctrl_pkg;

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_ARB   = 1'b1
   } state_t;

   localparam int XLEN_DEF = 32;
   localparam int AW_DEF   = 5;
   localparam int REG_LAST = 31;

   // Pointer width that stays at least one bit wide for a single requester.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: searches from ptr+1 upward, wrapping modulo N.
module rr_arbiter
   import regfile_ctrl_pkg::*;
#(
   parameter int N  = 2,
   parameter int PW = ptr_w(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [PW-1:0] o_idx,
   output logic          o_any
);

   int w_j;

   // First requester after the last-granted one wins.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_j     = 0;
      for (int k = 1; k <= N; k++) begin
         w_j = (int'(i_ptr) + k) % N;
         if (!o_any && i_req[w_j]) begin
            o_grant[w_j] = 1'b1;
            o_idx        = PW'(w_j);
            o_any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file write port among N_REQ writeback sources.
// Optional feature macro: REGFILE_CLEAR_EN adds a post-reset sweep that
// writes zero to x1..x31 before any requester is served.
module regfile_wr_arbiter
   import regfile_ctrl_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int XLEN  = XLEN_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hold,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [N_REQ*AW-1:0]   req_addr,
   input  logic [N_REQ*XLEN-1:0] req_data,
   output logic [N_REQ-1:0]      req_ready,
   output logic                  we_o,
   output logic [AW-1:0]         waddr_o,
   output logic [XLEN-1:0]       wdata_o,
   output logic                  init_done
);

   localparam int PW = ptr_w(N_REQ);

   logic [PW-1:0]    r_ptr;
   logic             r_we;
   logic [AW-1:0]    r_waddr;
   logic [XLEN-1:0]  r_wdata;
   logic             r_init_done;

   logic [N_REQ-1:0] w_grant;
   logic [PW-1:0]    w_idx;
   logic             w_any;
   logic             w_en;
   logic             w_xfer;
   logic             w_clear;
   logic [AW-1:0]    w_sel_addr;
   logic [XLEN-1:0]  w_sel_data;

`ifdef REGFILE_CLEAR_EN
   state_t           r_state;
   logic [4:0]       r_idx;
   assign w_clear = (r_state == S_CLEAR);
`else
   assign w_clear = 1'b0;
`endif

   rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // Grants only once serving and not frozen; init_done is low during the sweep.
   assign w_en       = r_init_done && !hold;
   assign req_ready  = w_en ? w_grant : '0;
   assign w_xfer     = w_en && w_any;
   assign w_sel_addr = req_addr[int'(w_idx)*AW +: AW];
   assign w_sel_data = req_data[int'(w_idx)*XLEN +: XLEN];

   // Clear sweep, pointer update and registered write port with x0 filter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr       <= PW'(N_REQ - 1);
         r_we        <= 1'b0;
         r_waddr     <= '0;
         r_wdata     <= '0;
         r_init_done <= 1'b0;
`ifdef REGFILE_CLEAR_EN
         r_state     <= S_CLEAR;
         r_idx       <= 5'd1;
`endif
      end else if (w_clear) begin
`ifdef REGFILE_CLEAR_EN
         r_we    <= 1'b1;
         r_waddr <= AW'(r_idx);
         r_wdata <= '0;
         r_idx   <= r_idx + 5'd1;
         if (r_idx == 5'(REG_LAST)) begin
            r_init_done <= 1'b1;
            r_state     <= S_ARB;
         end
`endif
      end else begin
         r_init_done <= 1'b1;
         if (w_xfer) begin
            r_ptr   <= w_idx;
            r_we    <= (w_sel_addr != '0);
            r_waddr <= w_sel_addr;
            r_wdata <= w_sel_data;
         end else begin
            r_we <= 1'b0;
         end
      end
   end

   assign we_o      = r_we;
   assign waddr_o   = r_waddr;
   assign wdata_o   = r_wdata;
   assign init_done = r_init_done;

endmodule
